// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode encodings, width defaults and decode helpers for the 8-bit RISC CPU
//
// Purpose : common definitions imported by the program counter slice.
// Contents: DEFAULT_ADDR_W / DEFAULT_OP_W width defaults, OP_HLT..OP_JMP
//           opcode encodings, is_mem_op() data-access opcode decode.
package cpu_pkg;

   localparam int DEFAULT_ADDR_W = 5;
   localparam int DEFAULT_OP_W   = 3;

   localparam logic [DEFAULT_OP_W-1:0] OP_HLT = 3'b000;
   localparam logic [DEFAULT_OP_W-1:0] OP_SKZ = 3'b001;
   localparam logic [DEFAULT_OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [DEFAULT_OP_W-1:0] OP_AND = 3'b011;
   localparam logic [DEFAULT_OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [DEFAULT_OP_W-1:0] OP_LDA = 3'b101;
   localparam logic [DEFAULT_OP_W-1:0] OP_STO = 3'b110;
   localparam logic [DEFAULT_OP_W-1:0] OP_JMP = 3'b111;

   // Opcodes whose operand field addresses data memory rather than code.
   function automatic logic is_mem_op(input logic [DEFAULT_OP_W-1:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_XOR) ||
             (opcode == OP_LDA) || (opcode == OP_STO);
   endfunction

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC selection for the program counter
//
// Purpose: computes the PC value to be registered on the next rising edge.
// Ports  : pc        in   current PC
//          addr      in   operand/target field of the current instruction
//          Opcode    in   opcode of the current instruction
//          SKZ_cmp   in   accumulator-is-zero flag
//          Load_in   in   external PC load strobe
//          En_cpu_in in   CPU enable (0 freezes the PC)
//          next_pc   out  PC value for the next edge
module pc_next_logic
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int OP_W   = DEFAULT_OP_W
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] addr,
   input  logic [OP_W-1:0]   Opcode,
   input  logic              SKZ_cmp,
   input  logic              Load_in,
   input  logic              En_cpu_in,
   output logic [ADDR_W-1:0] next_pc
);

   // Priority chain: disable beats load, load beats every opcode. Sums are
   // ADDR_W wide so wrap-around drops the carry naturally.
   always_comb begin
      next_pc = pc + ADDR_W'(1);
      if (!En_cpu_in) begin
         next_pc = pc;
      end else if (Load_in) begin
         next_pc = addr;
      end else if (Opcode == OP_JMP) begin
         next_pc = addr;
      end else if (Opcode == OP_HLT) begin
         next_pc = pc;
      end else if ((Opcode == OP_SKZ) && SKZ_cmp) begin
         next_pc = pc + ADDR_W'(2);
      end
   end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter register and memory address mux for the 8-bit RISC CPU
//
// Purpose: holds the PC, advances it via pc_next_logic, and drives the shared
//          instruction/data memory address bus.
// Ports  : clock           in   system clock, rising edge
//          reset           in   asynchronous active-low reset
//          addr            in   operand/target field of the current instruction
//          Opcode          in   opcode of the current instruction
//          SKZ_cmp         in   accumulator-is-zero flag
//          Load_in         in   external PC load strobe
//          En_cpu_in       in   CPU enable
//          Program_counter out  registered PC
//          Address         out  memory address bus (combinational)
module program_counter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int OP_W   = DEFAULT_OP_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [OP_W-1:0]   Opcode,
   input  logic              SKZ_cmp,
   input  logic              Load_in,
   input  logic              En_cpu_in,
   output logic [ADDR_W-1:0] Program_counter,
   output logic [ADDR_W-1:0] Address
);

   logic [ADDR_W-1:0] next_pc;

   pc_next_logic #(
      .ADDR_W (ADDR_W),
      .OP_W   (OP_W)
   ) u_pc_next_logic (
      .pc        (Program_counter),
      .addr      (addr),
      .Opcode    (Opcode),
      .SKZ_cmp   (SKZ_cmp),
      .Load_in   (Load_in),
      .En_cpu_in (En_cpu_in),
      .next_pc   (next_pc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Program_counter <= '0;
      end else begin
         Program_counter <= next_pc;
      end
   end

   // Data-access instructions put their operand on the bus; everything else
   // (including a pending external load) fetches from the PC. Reset forces 0
   // directly so the bus is clean even before the register has settled.
   always_comb begin
      Address = Program_counter;
      if (!reset) begin
         Address = '0;
      end else if (En_cpu_in && !Load_in && is_mem_op(Opcode)) begin
         Address = addr;
      end
   end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking randomized bench for program_counter
module tb_program_counter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] addr = '0;
   logic [2:0] Opcode = '0;
   logic       SKZ_cmp = 1'b0;
   logic       Load_in = 1'b0;
   logic       En_cpu_in = 1'b0;
   logic [4:0] Program_counter;
   logic [4:0] Address;

   int n_checks = 0;
   int n_errors = 0;
   int model_pc = 0;

   program_counter dut (
      .clock           (clock),
      .reset           (reset),
      .addr            (addr),
      .Opcode          (Opcode),
      .SKZ_cmp         (SKZ_cmp),
      .Load_in         (Load_in),
      .En_cpu_in       (En_cpu_in),
      .Program_counter (Program_counter),
      .Address         (Address)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference rules: 0 HLT, 1 SKZ, 2..6 data ops, 7 JMP; arithmetic mod 32.
   function automatic int ref_next(int pc, int a, int op, bit skz, bit ld, bit en);
      if (!en) return pc;
      if (ld || op == 7) return a;
      if (op == 0) return pc;
      if (op == 1 && skz) return (pc + 2) % 32;
      return (pc + 1) % 32;
   endfunction

   function automatic int ref_addr(int pc, int a, int op, bit ld, bit en, bit rst);
      if (!rst) return 0;
      if (en && !ld && op >= 2 && op <= 6) return a;
      return pc;
   endfunction

   // Called shortly after a rising edge: drive inputs, check the bus, then
   // advance one edge and check the PC.
   task automatic apply(input string tag, input int a, input int op,
                        input bit skz, input bit ld, input bit en);
      int nxt;
      addr = 5'(a); Opcode = 3'(op); SKZ_cmp = skz; Load_in = ld; En_cpu_in = en;
      #1;
      check_eq({tag, "_address"}, int'(Address), ref_addr(model_pc, a, op, ld, en, 1'b1));
      nxt = ref_next(model_pc, a, op, skz, ld, en);
      @(posedge clock);
      #1;
      model_pc = nxt;
      check_eq({tag, "_pc"}, int'(Program_counter), model_pc);
   endtask

   task automatic load_pc(input int v);
      apply("load", v, $urandom_range(0, 7), 1'b0, 1'b1, 1'b1);
   endtask

   // Asynchronous reset pulse between edges.
   task automatic pulse_reset(input string tag);
      reset = 1'b0;
      #1;
      model_pc = 0;
      check_eq({tag, "_rst_pc"}, int'(Program_counter), 0);
      check_eq({tag, "_rst_address"}, int'(Address), 0);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      // Reset state
      Opcode = 3'd5; addr = 5'd9; En_cpu_in = 1'b1;
      #2;
      check_eq("init_pc", int'(Program_counter), 0);
      check_eq("init_address", int'(Address), 0);
      @(posedge clock); #1;
      check_eq("held_reset_pc", int'(Program_counter), 0);
      reset = 1'b1;

      // 1: async reset from PC=7, then three increments
      load_pc(7);
      check_eq("t1_pc7", int'(Program_counter), 7);
      addr = 5'd9; Opcode = 3'd5; Load_in = 1'b0;
      pulse_reset("t1");
      for (int i = 0; i < 3; i++) apply("t1_add", $urandom_range(0, 31), 2, 1'b0, 1'b0, 1'b1);
      check_eq("t1_pc3", int'(Program_counter), 3);

      // 2: jumps
      apply("t2_jmp10", 10, 7, 1'b0, 1'b0, 1'b1);
      check_eq("t2_pc10", int'(Program_counter), 10);
      apply("t2_jmp15", 15, 7, 1'b0, 1'b0, 1'b1);
      check_eq("t2_pc15", int'(Program_counter), 15);

      // 3: skip-if-zero
      load_pc(10);
      apply("t3_skz1", 3, 1, 1'b1, 1'b0, 1'b1);
      check_eq("t3_pc12", int'(Program_counter), 12);
      load_pc(10);
      apply("t3_skz0", 3, 1, 1'b0, 1'b0, 1'b1);
      check_eq("t3_pc11", int'(Program_counter), 11);

      // 4: halt, load during halt
      load_pc(12);
      for (int i = 0; i < 3; i++) apply("t4_hlt", 21, 0, 1'b1, 1'b0, 1'b1);
      check_eq("t4_pc12", int'(Program_counter), 12);
      apply("t4_ld_hlt", 10, 0, 1'b0, 1'b1, 1'b1);
      check_eq("t4_pc10", int'(Program_counter), 10);
      apply("t4_hlt2", 3, 0, 1'b0, 1'b0, 1'b1);
      check_eq("t4_pc10b", int'(Program_counter), 10);

      // 5: wrap and disable
      load_pc(31);
      apply("t5_add_wrap", 0, 2, 1'b0, 1'b0, 1'b1);
      check_eq("t5_pc0", int'(Program_counter), 0);
      load_pc(30);
      apply("t5_skz_wrap", 0, 1, 1'b1, 1'b0, 1'b1);
      check_eq("t5_pc0b", int'(Program_counter), 0);
      load_pc(31);
      apply("t5_skz_wrap1", 0, 1, 1'b1, 1'b0, 1'b1);
      check_eq("t5_pc1", int'(Program_counter), 1);
      apply("t5_dis_jmp", 5, 7, 1'b0, 1'b0, 1'b0);
      check_eq("t5_pc1b", int'(Program_counter), 1);
      apply("t5_dis_ld", 5, 0, 1'b0, 1'b1, 1'b0);
      check_eq("t5_pc1c", int'(Program_counter), 1);

      // 6: address mux
      load_pc(4);
      addr = 5'd20; Opcode = 3'd5; Load_in = 1'b0; En_cpu_in = 1'b1; #1;
      check_eq("t6_lda", int'(Address), 20);
      Opcode = 3'd7; #1;
      check_eq("t6_jmp", int'(Address), 4);
      Opcode = 3'd1; #1;
      check_eq("t6_skz", int'(Address), 4);
      Opcode = 3'd5; Load_in = 1'b1; #1;
      check_eq("t6_lda_ld", int'(Address), 4);
      Load_in = 1'b0; En_cpu_in = 1'b0; #1;
      check_eq("t6_lda_dis", int'(Address), 4);

      // Randomized run with occasional mid-operation resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset("rnd");
         apply("rnd", $urandom_range(0, 31), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
